tick_timekeeper: RTL and testbench

Consumer end of the divided clock. Samples the slow clk_out of the clock divider as data in the clk_in domain, detects its rising edges and advances a binary HH:MM:SS time-of-day counter. Accepts time loads over a valid/ready handshake. Monitors the tick period and flags a divider that is too fast, too slow or stalled.

---
 rtl/tick_pkg.sv | 24 ++
 rtl/tick_timekeeper_if.sv | 20 ++
 rtl/tick_timekeeper_sync_edge_detect.sv | 32 +++
 rtl/tick_timekeeper.sv | 180 ++++++++++++++++++
 tb/tb_tick_timekeeper.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for the tick time-keeper.
//   Field widths and limits of the HH:MM:SS counter, the state encodings of
//   the period monitor and of the load handshake, and a range check used to
//   validate time loads.
package tick_pkg;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam int SS_W = 6;

  localparam logic [HH_W-1:0] HH_MAX = 5'd23;
  localparam logic [MM_W-1:0] MM_MAX = 6'd59;
  localparam logic [SS_W-1:0] SS_MAX = 6'd59;

  typedef enum logic {ARM, MEASURE} mon_state_t;
  typedef enum logic {IDLE, LOAD} load_state_t;

  function automatic logic time_in_range(input logic [HH_W-1:0] h,
                                         input logic [MM_W-1:0] m,
                                         input logic [SS_W-1:0] s);
    return (h <= HH_MAX) && (m <= MM_MAX) && (s <= SS_MAX);
  endfunction

endpackage

// File: rtl/tick_timekeeper_if.sv
// Time-load channel of the tick time-keeper.
//   set_valid/set_ready : valid/ready handshake, transfer on valid & ready
//   set_hh/mm/ss        : requested time, sampled at the transfer
//   set_nack            : one-cycle pulse, accepted load was out of range
// master = load requester, slave = time-keeper.
interface tick_timekeeper_if;
  import tick_pkg::*;

  logic            set_valid;
  logic            set_ready;
  logic [HH_W-1:0] set_hh;
  logic [MM_W-1:0] set_mm;
  logic [SS_W-1:0] set_ss;
  logic            set_nack;

  modport master (output set_valid, set_hh, set_mm, set_ss,
                  input  set_ready, set_nack);
  modport slave  (input  set_valid, set_hh, set_mm, set_ss,
                  output set_ready, set_nack);
endinterface

// File: rtl/tick_timekeeper_sync_edge_detect.sv
// Synchronizer plus rising-edge strobe for an asynchronous level input.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous input, must be glitch-free
//   rise  : one-cycle strobe, high while the synchronized level is 1 and the
//           history flop still holds 0
// With STAGES=2 the strobe is high in the cycle after the second capture.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      hist_reg <= sync_reg[STAGES-1];
    end
  end

  assign rise = sync_reg[STAGES-1] & ~hist_reg;

endmodule

// File: rtl/tick_timekeeper.sv
// Time-of-day keeper driven by a divided clock treated as data.
//   clk_in, rst_n : system clock, asynchronous active-low reset
//   tick_clk      : divided clock; each rising edge advances HH:MM:SS
//   set_if        : time-load handshake (slave side)
//   hh, mm, ss    : current time, binary
//   sec_pulse     : one-cycle pulse coincident with each time advance
//   tick_err      : sticky flag, tick period out of tolerance or stalled
//   err_clr       : clears tick_err (a new error in the same cycle wins)
//   last_period   : clk_in cycles between the last two measured edges
module tick_timekeeper import tick_pkg::*; #(
  parameter int TICK_CYCLES = 20000000,
  parameter int TOL_CYCLES  = 1000,
  parameter int CNT_W       = 26
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_clk,
  tick_timekeeper_if.slave set_if,
  output logic [HH_W-1:0]  hh,
  output logic [MM_W-1:0]  mm,
  output logic [SS_W-1:0]  ss,
  output logic             sec_pulse,
  output logic             tick_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] last_period
);

  // Period limits in the one-bit-wider domain of counter+1.
  localparam logic [CNT_W:0] PER_LO   = (CNT_W+1)'(TICK_CYCLES - TOL_CYCLES);
  localparam logic [CNT_W:0] PER_HI   = (CNT_W+1)'(TICK_CYCLES + TOL_CYCLES);
  localparam logic [CNT_W:0] STALL_AT = (CNT_W+1)'(TICK_CYCLES + TOL_CYCLES + 1);

  logic tick_rise;

  sync_edge_detect #(.STAGES(2)) u_tick_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .din   (tick_clk),
    .rise  (tick_rise)
  );

  // ---------------- load handshake ----------------
  load_state_t     load_state_reg, load_state_next;
  logic [HH_W-1:0] ld_hh_reg;
  logic [MM_W-1:0] ld_mm_reg;
  logic [SS_W-1:0] ld_ss_reg;
  logic            transfer;
  logic            ld_ok;

  assign set_if.set_ready = (load_state_reg == IDLE);
  assign transfer         = set_if.set_valid & set_if.set_ready;
  assign ld_ok            = time_in_range(ld_hh_reg, ld_mm_reg, ld_ss_reg);
  assign set_if.set_nack  = (load_state_reg == LOAD) & ~ld_ok;

  always_comb begin
    load_state_next = load_state_reg;
    case (load_state_reg)
      IDLE:    if (transfer) load_state_next = LOAD;
      LOAD:    load_state_next = IDLE;
      default: load_state_next = IDLE;
    endcase
  end

  // ---------------- time counter ----------------
  logic [HH_W-1:0] hh_reg, hh_next;
  logic [MM_W-1:0] mm_reg, mm_next;
  logic [SS_W-1:0] ss_reg, ss_next;
  logic            sec_pulse_reg, sec_pulse_next;

  // A LOAD cycle owns the time registers; an edge strobe landing in it is
  // dropped here (the monitor still sees it).
  always_comb begin
    hh_next        = hh_reg;
    mm_next        = mm_reg;
    ss_next        = ss_reg;
    sec_pulse_next = 1'b0;
    if (load_state_reg == LOAD) begin
      if (ld_ok) begin
        hh_next = ld_hh_reg;
        mm_next = ld_mm_reg;
        ss_next = ld_ss_reg;
      end
    end else if (tick_rise) begin
      sec_pulse_next = 1'b1;
      if (ss_reg == SS_MAX) begin
        ss_next = '0;
        if (mm_reg == MM_MAX) begin
          mm_next = '0;
          hh_next = (hh_reg == HH_MAX) ? '0 : hh_reg + 1'b1;
        end else begin
          mm_next = mm_reg + 1'b1;
        end
      end else begin
        ss_next = ss_reg + 1'b1;
      end
    end
  end

  // ---------------- period monitor ----------------
  mon_state_t       mon_state_reg, mon_state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] last_period_reg, last_period_next;
  logic             tick_err_reg, tick_err_next;
  logic             new_err;

  assign cnt_inc = {1'b0, cnt_reg} + (CNT_W+1)'(1);
  assign cnt_sat = (&cnt_reg) ? cnt_reg : cnt_inc[CNT_W-1:0];

  always_comb begin
    mon_state_next   = mon_state_reg;
    cnt_next         = cnt_reg;
    last_period_next = last_period_reg;
    new_err          = 1'b0;
    case (mon_state_reg)
      ARM: begin
        cnt_next = '0;
        if (tick_rise) mon_state_next = MEASURE;
      end
      MEASURE: begin
        if (tick_rise) begin
          last_period_next = cnt_sat;
          cnt_next         = '0;
          new_err          = (cnt_inc < PER_LO) || (cnt_inc > PER_HI);
        end else if (cnt_inc == STALL_AT) begin
          // No edge inside the tolerance window: flag once, wait for re-arm.
          new_err        = 1'b1;
          cnt_next       = '0;
          mon_state_next = ARM;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      default: mon_state_next = ARM;
    endcase
    tick_err_next = new_err ? 1'b1 : (err_clr ? 1'b0 : tick_err_reg);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      load_state_reg  <= IDLE;
      ld_hh_reg       <= '0;
      ld_mm_reg       <= '0;
      ld_ss_reg       <= '0;
      hh_reg          <= '0;
      mm_reg          <= '0;
      ss_reg          <= '0;
      sec_pulse_reg   <= 1'b0;
      mon_state_reg   <= ARM;
      cnt_reg         <= '0;
      last_period_reg <= '0;
      tick_err_reg    <= 1'b0;
    end else begin
      load_state_reg  <= load_state_next;
      if (transfer) begin
        ld_hh_reg <= set_if.set_hh;
        ld_mm_reg <= set_if.set_mm;
        ld_ss_reg <= set_if.set_ss;
      end
      hh_reg          <= hh_next;
      mm_reg          <= mm_next;
      ss_reg          <= ss_next;
      sec_pulse_reg   <= sec_pulse_next;
      mon_state_reg   <= mon_state_next;
      cnt_reg         <= cnt_next;
      last_period_reg <= last_period_next;
      tick_err_reg    <= tick_err_next;
    end
  end

  assign hh          = hh_reg;
  assign mm          = mm_reg;
  assign ss          = ss_reg;
  assign sec_pulse   = sec_pulse_reg;
  assign tick_err    = tick_err_reg;
  assign last_period = last_period_reg;

endmodule

// File: tb/tb_tick_timekeeper.sv
module tb_tick_timekeeper;

  localparam int TC = 10;
  localparam int TL = 2;
  localparam int CW = 8;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_clk = 1'b0;
  logic          err_clr = 1'b0;
  logic [4:0]    hh;
  logic [5:0]    mm;
  logic [5:0]    ss;
  logic          sec_pulse;
  logic          tick_err;
  logic [CW-1:0] last_period;
  logic [16:0]   dut_time;

  tick_timekeeper_if sif();

  tick_timekeeper #(.TICK_CYCLES(TC), .TOL_CYCLES(TL), .CNT_W(CW)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .tick_clk    (tick_clk),
    .set_if      (sif),
    .hh          (hh),
    .mm          (mm),
    .ss          (ss),
    .sec_pulse   (sec_pulse),
    .tick_err    (tick_err),
    .err_clr     (err_clr),
    .last_period (last_period)
  );

  always #5 clk_in = ~clk_in;
  assign dut_time = {hh, mm, ss};

  int n_run = 0;
  int n_fail = 0;
  int ph = 0;
  bit tick_en = 0;

  // ---------------- reference model ----------------
  // Time is kept as seconds of day; tick periods are differences of the
  // cycle stamps at which each tick rise takes effect (2 cycles after the
  // cycle in which the rise is first sampled).
  int cyc = 0;
  int m_secs = 0, m_ld_secs = 0, m_last = 0, m_last_edge = 0;
  bit m_load = 0, m_ld_ok = 0, m_pulse = 0, m_err = 0, m_meas = 0, m_prev_tick = 0;
  int pend[$];
  bit landed, new_err;
  int per;

  initial forever begin
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      m_secs = 0; m_load = 0; m_ld_ok = 0; m_pulse = 0; m_err = 0;
      m_last = 0; m_meas = 0; m_prev_tick = 0; pend.delete();
    end else begin
      cyc++;
      landed = 0;
      if (pend.size() > 0 && pend[0] == cyc) begin
        landed = 1;
        void'(pend.pop_front());
      end
      if (tick_clk && !m_prev_tick) pend.push_back(cyc + 2);
      m_prev_tick = tick_clk;
      m_pulse = 0;
      if (m_load) begin
        if (m_ld_ok) m_secs = m_ld_secs;
        m_load = 0;
      end else begin
        if (landed) begin
          m_secs = (m_secs + 1) % 86400;
          m_pulse = 1;
        end
        if (sif.set_valid) begin
          m_load = 1;
          m_ld_ok = (sif.set_hh <= 23) && (sif.set_mm <= 59) && (sif.set_ss <= 59);
          m_ld_secs = int'(sif.set_hh) * 3600 + int'(sif.set_mm) * 60 + int'(sif.set_ss);
        end
      end
      new_err = 0;
      if (landed) begin
        if (m_meas) begin
          per = cyc - m_last_edge;
          m_last = per;
          if (per < TC - TL || per > TC + TL) new_err = 1;
        end
        m_meas = 1;
        m_last_edge = cyc;
      end else if (m_meas && (cyc - m_last_edge) == TC + TL + 1) begin
        new_err = 1;
        m_meas = 0;
      end
      if (new_err) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  function automatic logic [16:0] exp_time();
    return {5'(m_secs / 3600), 6'((m_secs / 60) % 60), 6'(m_secs % 60)};
  endfunction

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  // One clock; inputs are set before the call, outputs are read 1 time unit
  // after the rising edge.
  task automatic step();
    if (tick_en) tick_clk = ((ph % 10) >= 5);
    @(posedge clk_in);
    #1;
    ph++;
  endtask

  task automatic idle_set();
    sif.set_valid = 0; sif.set_hh = '0; sif.set_mm = '0; sif.set_ss = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; idle_set(); err_clr = 0; tick_clk = 0;
    repeat (3) step();
    n_run++; if (dut_time !== 17'd0) begin n_fail++; $display("FAIL reset_time got=%h exp=0", dut_time); end
    n_run++; if (sec_pulse !== 1'b0 || sif.set_nack !== 1'b0 || tick_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got pulse=%b nack=%b err=%b exp=0", sec_pulse, sif.set_nack, tick_err); end
    n_run++; if (last_period !== '0) begin n_fail++; $display("FAIL reset_period got=%0d exp=0", last_period); end
    n_run++; if (sif.set_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", sif.set_ready); end
    rst_n = 1;
    step();
  endtask

  task automatic test_count();
    tick_en = 1; ph = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      n_run++; if (dut_time !== exp_time() || sec_pulse !== m_pulse) begin
        n_fail++; $display("FAIL count cyc%0d got=%h/%b exp=%h/%b", i, dut_time, sec_pulse, exp_time(), m_pulse); end
    end
    n_run++; if (dut_time !== hms(0, 0, 6)) begin n_fail++; $display("FAIL count_final got=%h exp=%h", dut_time, hms(0, 0, 6)); end
    n_run++; if (last_period !== 8'd10 || tick_err !== 1'b0) begin
      n_fail++; $display("FAIL count_period got=%0d/%b exp=10/0", last_period, tick_err); end
  endtask

  task automatic test_load_wrap();
    logic [16:0] want [2];
    int idx = 0;
    want[0] = hms(23, 59, 59);
    want[1] = hms(0, 0, 0);
    while (ph % 10 != 0) step();
    sif.set_valid = 1; sif.set_hh = 5'd23; sif.set_mm = 6'd59; sif.set_ss = 6'd58;
    step();
    idle_set();
    n_run++; if (sif.set_ready !== 1'b0 || sif.set_nack !== 1'b0) begin
      n_fail++; $display("FAIL load_busy got ready=%b nack=%b exp 0/0", sif.set_ready, sif.set_nack); end
    step();
    n_run++; if (dut_time !== hms(23, 59, 58) || sif.set_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_value got=%h/%b exp=%h/1", dut_time, sif.set_ready, hms(23, 59, 58)); end
    for (int i = 0; i < 25; i++) begin
      step();
      n_run++; if (sec_pulse !== m_pulse) begin n_fail++; $display("FAIL wrap_pulse got=%b exp=%b", sec_pulse, m_pulse); end
      if (m_pulse && idx < 2) begin
        n_run++; if (dut_time !== want[idx]) begin n_fail++; $display("FAIL wrap_time%0d got=%h exp=%h", idx, dut_time, want[idx]); end
        idx++;
      end
    end
    n_run++; if (idx != 2) begin n_fail++; $display("FAIL wrap_edges got=%0d exp=2", idx); end
  endtask

  task automatic test_nack();
    while (ph % 10 != 0) step();
    sif.set_valid = 1; sif.set_hh = 5'd24; sif.set_mm = 6'd10; sif.set_ss = 6'd0;
    step();
    idle_set();
    n_run++; if (sif.set_nack !== 1'b1 || sif.set_ready !== 1'b0) begin
      n_fail++; $display("FAIL nack_pulse got nack=%b ready=%b exp 1/0", sif.set_nack, sif.set_ready); end
    step();
    n_run++; if (sif.set_nack !== 1'b0) begin n_fail++; $display("FAIL nack_len got=%b exp=0", sif.set_nack); end
    n_run++; if (dut_time !== hms(0, 0, 1)) begin n_fail++; $display("FAIL nack_time got=%h exp=%h", dut_time, hms(0, 0, 1)); end
  endtask

  task automatic test_collision();
    int guard = 0;
    while (ph % 10 != 6) step();
    sif.set_valid = 1; sif.set_hh = 5'd5; sif.set_mm = 6'd59; sif.set_ss = 6'd59;
    step();
    idle_set();
    step();
    n_run++; if (sec_pulse !== 1'b0 || dut_time !== hms(5, 59, 59)) begin
      n_fail++; $display("FAIL collide got=%h/%b exp=%h/0", dut_time, sec_pulse, hms(5, 59, 59)); end
    do begin step(); guard++; end while (!m_pulse && guard < 15);
    n_run++; if (guard >= 15) begin n_fail++; $display("FAIL collide_timeout got=%0d cycles exp<15", guard); end
    n_run++; if (sec_pulse !== 1'b1 || dut_time !== hms(6, 0, 0)) begin
      n_fail++; $display("FAIL collide_next got=%h/%b exp=%h/1", dut_time, sec_pulse, hms(6, 0, 0)); end
    n_run++; if (last_period !== 8'd10 || tick_err !== 1'b0) begin
      n_fail++; $display("FAIL collide_monitor got=%0d/%b exp=10/0", last_period, tick_err); end
  endtask

  task automatic test_period_err();
    int gaps [5] = '{10, 10, 7, 10, 10};
    while (ph % 10 != 5) step();
    tick_en = 0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < gaps[g]; i++) begin
        tick_clk = (i < gaps[g] / 2);
        step();
        n_run++; if (tick_err !== m_err || last_period !== CW'(m_last)) begin
          n_fail++; $display("FAIL period_track got=%b/%0d exp=%b/%0d", tick_err, last_period, m_err, m_last); end
      end
      if (g == 3) begin
        n_run++; if (tick_err !== 1'b1 || last_period !== 8'd7) begin
          n_fail++; $display("FAIL period_short got=%b/%0d exp=1/7", tick_err, last_period); end
      end
    end
    n_run++; if (tick_err !== 1'b1 || last_period !== 8'd10) begin
      n_fail++; $display("FAIL period_sticky got=%b/%0d exp=1/10", tick_err, last_period); end
    err_clr = 1; step(); err_clr = 0;
    n_run++; if (tick_err !== 1'b0) begin n_fail++; $display("FAIL period_clr got=%b exp=0", tick_err); end
  endtask

  task automatic test_stall();
    tick_clk = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_run++; if (tick_err !== m_err) begin n_fail++; $display("FAIL stall_track got=%b exp=%b", tick_err, m_err); end
      if (i == 3) begin
        n_run++; if (tick_err !== 1'b0) begin n_fail++; $display("FAIL stall_early got=%b exp=0", tick_err); end
      end
      if (i == 4) begin
        n_run++; if (tick_err !== 1'b1) begin n_fail++; $display("FAIL stall_flag got=%b exp=1", tick_err); end
      end
    end
    err_clr = 1; step(); err_clr = 0;
    n_run++; if (tick_err !== 1'b0) begin n_fail++; $display("FAIL stall_clr got=%b exp=0", tick_err); end
    tick_en = 1; ph = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      n_run++; if (tick_err !== m_err) begin n_fail++; $display("FAIL resume_track got=%b exp=%b", tick_err, m_err); end
    end
    n_run++; if (tick_err !== 1'b0 || last_period !== 8'd10) begin
      n_fail++; $display("FAIL resume got=%b/%0d exp=0/10", tick_err, last_period); end
    tick_en = 0;
  endtask

  task automatic test_random();
    int gap;
    for (int g = 0; g < 40; g++) begin
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(9, 11));
      for (int i = 0; i < gap; i++) begin
        tick_clk = (i < gap / 2);
        sif.set_valid = ($urandom_range(0, 3) == 0);
        sif.set_hh = 5'($urandom_range(0, 25));
        sif.set_mm = 6'($urandom_range(0, 62));
        sif.set_ss = 6'($urandom_range(0, 62));
        err_clr = ($urandom_range(0, 15) == 0);
        step();
        n_run++; if (dut_time !== exp_time() || sec_pulse !== m_pulse) begin
          n_fail++; $display("FAIL rnd_time got=%h/%b exp=%h/%b", dut_time, sec_pulse, exp_time(), m_pulse); end
        n_run++; if (sif.set_ready !== !m_load || sif.set_nack !== (m_load && !m_ld_ok)) begin
          n_fail++; $display("FAIL rnd_hs got=%b/%b exp=%b/%b", sif.set_ready, sif.set_nack, !m_load, m_load && !m_ld_ok); end
        n_run++; if (tick_err !== m_err || last_period !== CW'(m_last)) begin
          n_fail++; $display("FAIL rnd_mon got=%b/%0d exp=%b/%0d", tick_err, last_period, m_err, m_last); end
      end
    end
    idle_set(); err_clr = 0;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    rst_n = 0; #1;
    n_run++; if (dut_time !== 17'd0 || sif.set_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_async1 got=%h/%b exp=0/1", dut_time, sif.set_ready); end
    step(); step();
    rst_n = 1;
    tick_en = 1; ph = 0;
    while (m_secs != 7 && guard < 150) begin step(); guard++; end
    n_run++; if (dut_time !== hms(0, 0, 7)) begin n_fail++; $display("FAIL rst_pre got=%h exp=%h", dut_time, hms(0, 0, 7)); end
    rst_n = 0; #1;
    n_run++; if (dut_time !== 17'd0 || sec_pulse !== 1'b0 || tick_err !== 1'b0 || last_period !== '0) begin
      n_fail++; $display("FAIL rst_async2 got=%h/%b/%b/%0d exp=0", dut_time, sec_pulse, tick_err, last_period); end
    n_run++; if (sif.set_ready !== 1'b1 || sif.set_nack !== 1'b0) begin
      n_fail++; $display("FAIL rst_hs got=%b/%b exp=1/0", sif.set_ready, sif.set_nack); end
    tick_en = 0;
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_wrap();
    test_nack();
    test_collision();
    test_period_err();
    test_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no-finish exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
